// File: rtl/fpu_result_checker.sv
// FPU result checker: delays each issued golden value by the FPU latency, compares it
// with the FPU Result bus, classifies the compare (match / 1-ULP round / mismatch), keeps
// saturating statistics and captures the first mismatch.
module fpu_result_checker #(
   parameter int unsigned LATENCY = 8,
   parameter int unsigned CNT_W   = 32
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             InValid,
   input  logic [31:0]      Expected,
   input  logic [31:0]      Result,
   input  logic             Clear,
   output logic             ChkValid,
   output logic             IsMatch,
   output logic             IsRound,
   output logic             IsMismatch,
   output logic [CNT_W-1:0] NumM,
   output logic [CNT_W-1:0] NumR,
   output logic [CNT_W-1:0] NumD,
   output logic [CNT_W-1:0] Outstanding,
   output logic             ErrSeen,
   output logic [31:0]      ErrResult,
   output logic [31:0]      ErrExpected,
   output logic [CNT_W-1:0] ErrIndex
);

   localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
   localparam logic [CNT_W-1:0] CntMax = '1;

   logic [LATENCY-1:0]       vld_q, vld_d;
   logic [LATENCY-1:0][31:0] dat_q, dat_d;

   logic             chk_valid_q, chk_valid_d;
   logic             is_match_q, is_match_d;
   logic             is_round_q, is_round_d;
   logic             is_mism_q, is_mism_d;
   logic [CNT_W-1:0] num_m_q, num_m_d;
   logic [CNT_W-1:0] num_r_q, num_r_d;
   logic [CNT_W-1:0] num_d_q, num_d_d;
   logic [CNT_W-1:0] outst_q, outst_d;
   logic [CNT_W-1:0] cmp_idx_q, cmp_idx_d;
   logic             err_seen_q, err_seen_d;
   logic [31:0]      err_res_q, err_res_d;
   logic [31:0]      err_exp_q, err_exp_d;
   logic [CNT_W-1:0] err_idx_q, err_idx_d;

   logic        cmp_vld;
   logic [31:0] exp_al;
   logic [31:0] diff;
   logic        cls_m, cls_r, cls_d;

   // Delay line: stage 0 captures the issue, the last stage is the aligned entry.
   always_comb begin
      vld_d    = vld_q;
      dat_d    = dat_q;
      vld_d[0] = InValid;
      dat_d[0] = Expected;
      for (int i = 1; i < int'(LATENCY); i++) begin
         vld_d[i] = vld_q[i-1];
         dat_d[i] = dat_q[i-1];
      end
   end

   // Classification of the aligned entry against the current Result bus.
   always_comb begin
      cmp_vld = vld_q[LATENCY-1];
      exp_al  = dat_q[LATENCY-1];
      diff    = Result - exp_al;
      cls_m   = (diff == 32'h0);
      cls_r   = (diff == 32'h1) || (diff == 32'hFFFF_FFFF);
      cls_d   = !cls_m && !cls_r;
   end

   // Next-state for flags, statistics, outstanding tracking and first-error capture.
   always_comb begin
      chk_valid_d = cmp_vld;
      is_match_d  = cmp_vld && cls_m;
      is_round_d  = cmp_vld && cls_r;
      is_mism_d   = cmp_vld && cls_d;

      num_m_d    = num_m_q;
      num_r_d    = num_r_q;
      num_d_d    = num_d_q;
      cmp_idx_d  = cmp_idx_q;
      err_seen_d = err_seen_q;
      err_res_d  = err_res_q;
      err_exp_d  = err_exp_q;
      err_idx_d  = err_idx_q;

      // Clear wins over a compare on the same edge: the compare is flagged but not counted.
      if (Clear) begin
         num_m_d    = '0;
         num_r_d    = '0;
         num_d_d    = '0;
         cmp_idx_d  = '0;
         err_seen_d = 1'b0;
         err_res_d  = '0;
         err_exp_d  = '0;
         err_idx_d  = '0;
      end else if (cmp_vld) begin
         cmp_idx_d = cmp_idx_q + CntOne;
         if (cls_m && num_m_q != CntMax) num_m_d = num_m_q + CntOne;
         if (cls_r && num_r_q != CntMax) num_r_d = num_r_q + CntOne;
         if (cls_d && num_d_q != CntMax) num_d_d = num_d_q + CntOne;
         if (cls_d && !err_seen_q) begin
            err_seen_d = 1'b1;
            err_res_d  = Result;
            err_exp_d  = exp_al;
            err_idx_d  = cmp_idx_q;
         end
      end

      // Outstanding is not affected by Clear since the delay line keeps its contents.
      outst_d = outst_q;
      unique case ({InValid, cmp_vld})
         2'b10:   outst_d = outst_q + CntOne;
         2'b01:   outst_d = outst_q - CntOne;
         default: outst_d = outst_q;
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         vld_q       <= '0;
         dat_q       <= '0;
         chk_valid_q <= 1'b0;
         is_match_q  <= 1'b0;
         is_round_q  <= 1'b0;
         is_mism_q   <= 1'b0;
         num_m_q     <= '0;
         num_r_q     <= '0;
         num_d_q     <= '0;
         outst_q     <= '0;
         cmp_idx_q   <= '0;
         err_seen_q  <= 1'b0;
         err_res_q   <= '0;
         err_exp_q   <= '0;
         err_idx_q   <= '0;
      end else begin
         vld_q       <= vld_d;
         dat_q       <= dat_d;
         chk_valid_q <= chk_valid_d;
         is_match_q  <= is_match_d;
         is_round_q  <= is_round_d;
         is_mism_q   <= is_mism_d;
         num_m_q     <= num_m_d;
         num_r_q     <= num_r_d;
         num_d_q     <= num_d_d;
         outst_q     <= outst_d;
         cmp_idx_q   <= cmp_idx_d;
         err_seen_q  <= err_seen_d;
         err_res_q   <= err_res_d;
         err_exp_q   <= err_exp_d;
         err_idx_q   <= err_idx_d;
      end
   end

   assign ChkValid    = chk_valid_q;
   assign IsMatch     = is_match_q;
   assign IsRound     = is_round_q;
   assign IsMismatch  = is_mism_q;
   assign NumM        = num_m_q;
   assign NumR        = num_r_q;
   assign NumD        = num_d_q;
   assign Outstanding = outst_q;
   assign ErrSeen     = err_seen_q;
   assign ErrResult   = err_res_q;
   assign ErrExpected = err_exp_q;
   assign ErrIndex    = err_idx_q;

endmodule
